// File: rtl/reg_bus_master.sv
// Bus initiator for the 16 x 16-bit register file: sequences READ, WRITE, COPY
// and SWAP requests as one register-file transfer per cycle over the shared data bus.
module reg_bus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [15:0] wdata,
    output logic        rsp_valid,
    output logic [15:0] rdata,
    output logic [3:0]  register_select,
    output logic        reg_file_in,
    output logic        reg_file_out,
    inout  wire  [15:0] data
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        RESP
    } state_t;

    state_t      state, state_next;
    op_t         op_q, op_cur;
    logic [3:0]  rd_q, rs_q, rd_cur, rs_cur;
    logic [15:0] tmp_a, tmp_b, tmp_a_next, tmp_b_next;
    logic [15:0] drive_q, drive_next;
    logic [3:0]  sel_next;
    logic        accept;

    assign accept = (state == IDLE) && req_valid;

    // On the acceptance edge the latched fields are not yet valid, so the
    // first bus cycle is decoded straight from the request inputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        op_cur     = accept ? op_t'(op) : op_q;
        rd_cur     = accept ? rd : rd_q;
        rs_cur     = accept ? rs : rs_q;
        state_next = state;
        tmp_a_next = tmp_a;
        tmp_b_next = tmp_b;
        sel_next   = 4'd0;
        drive_next = 16'd0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_cur == OP_WRITE) begin
                        state_next = WR_A;
                        tmp_a_next = wdata;
                    end else begin
                        state_next = RD_A;
                    end
                end
            end
            RD_A: begin
                tmp_a_next = data;
                case (op_q)
                    OP_READ: state_next = RESP;
                    OP_COPY: state_next = WR_A;
                    default: state_next = RD_B;
                endcase
            end
            RD_B: begin
                tmp_b_next = data;
                state_next = WR_A;
            end
            WR_A:    state_next = (op_q == OP_SWAP) ? WR_B : RESP;
            WR_B:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Bus outputs are decoded from the next state and registered below.
        case (state_next)
            RD_A: sel_next = rs_cur;
            RD_B: sel_next = rd_cur;
            WR_A: begin
                sel_next   = rd_cur;
                drive_next = tmp_a_next;
            end
            WR_B: begin
                sel_next   = rs_cur;
                drive_next = tmp_b_next;
            end
            default: sel_next = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: the scratch registers are reset too, so rdata and the bus
        // drive value never expose stale contents after reset.
        if (rst) begin
            op_q            <= OP_READ;
            rd_q            <= 4'd0;
            rs_q            <= 4'd0;
            tmp_a           <= 16'd0;
            tmp_b           <= 16'd0;
            drive_q         <= 16'd0;
            register_select <= 4'd0;
            reg_file_in     <= 1'b0;
            reg_file_out    <= 1'b0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rdata           <= 16'd0;
        end else begin
            if (accept) begin
                op_q <= op_cur;
                rd_q <= rd;
                rs_q <= rs;
            end
            tmp_a           <= tmp_a_next;
            tmp_b           <= tmp_b_next;
            drive_q         <= drive_next;
            register_select <= sel_next;
            reg_file_in     <= (state_next == WR_A) || (state_next == WR_B);
            reg_file_out    <= (state_next == RD_A) || (state_next == RD_B);
            req_ready       <= (state_next == IDLE);
            rsp_valid       <= (state_next == RESP);
            if (state_next == RESP) rdata <= tmp_a_next;
        end
    end

    assign data = reg_file_in ? drive_q : 16'bz;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed self-checking bench for reg_bus_master with a behavioural register
// file on the shared bus and a per-cycle bus-protocol monitor.
module tb_reg_bus_master;

    localparam logic [1:0]  OP_READ  = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_COPY  = 2'b10;
    localparam logic [1:0]  OP_SWAP  = 2'b11;
    localparam logic [15:0] PROBE    = 16'hC35A;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] wdata;
    logic        rsp_valid;
    logic [15:0] rdata;
    logic [3:0]  register_select;
    logic        reg_file_in;
    logic        reg_file_out;
    wire  [15:0] data;

    logic [15:0] regs [16];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          bus_cnt = 0;

    reg_bus_master dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .op              (op),
        .rd              (rd),
        .rs              (rs),
        .wdata           (wdata),
        .rsp_valid       (rsp_valid),
        .rdata           (rdata),
        .register_select (register_select),
        .reg_file_in     (reg_file_in),
        .reg_file_out    (reg_file_out),
        .data            (data)
    );

    always #5 clk = ~clk;

    // Register file model; when nobody should own the bus a known probe value
    // is driven so any stray drive from the master corrupts it.
    assign data = reg_file_out ? regs[register_select] : 16'bz;
    assign data = (!reg_file_out && !reg_file_in) ? PROBE : 16'bz;

    always @(posedge clk) begin
        if (reg_file_in) regs[register_select] <= data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("strobe_exclusive", {31'd0, reg_file_in & reg_file_out}, 32'd0);
        if (reg_file_out) check("bus_read_value", {16'd0, data}, {16'd0, regs[register_select]});
        else if (!reg_file_in) check("bus_released", {16'd0, data}, {16'd0, PROBE});
        if (reg_file_in) wr_cnt++;
        if (reg_file_in || reg_file_out) bus_cnt++;
    end

    task automatic do_op(input string tag, input logic [1:0] o, input logic [3:0] d,
                         input logic [3:0] s, input logic [15:0] w, input logic [15:0] exp_rdata,
                         input int exp_lat, input int exp_bus, input int exp_wr);
        int lat;
        int wr0;
        int bus0;
        bit got;
        @(negedge clk);
        #1;
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op        = o;
        rd        = d;
        rs        = s;
        wdata     = w;
        @(posedge clk);
        #1;
        // Junk request held while busy must be ignored.
        op    = OP_WRITE;
        rd    = 4'd0;
        rs    = 4'd0;
        wdata = 16'hDEAD;
        wr0   = wr_cnt;
        bus0  = bus_cnt;
        lat   = 0;
        got   = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
            check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
            if (rsp_valid) got = 1'b1;
        end
        req_valid = 1'b0;
        check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rdata});
        check({tag, "_bus_cycles"}, bus_cnt - bus0, exp_bus);
        check({tag, "_write_strobes"}, wr_cnt - wr0, exp_wr);
        @(negedge clk);
        #1;
        check({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int wr0;
        for (int i = 0; i < 16; i++) regs[i] = 16'd0;
        rst       = 1'b1;
        req_valid = 1'b1;
        op        = OP_WRITE;
        rd        = 4'd5;
        rs        = 4'd0;
        wdata     = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", {16'd0, rdata}, 32'd0);
        check("reset_select", {28'd0, register_select}, 32'd0);
        check("reset_in", {31'd0, reg_file_in}, 32'd0);
        check("reset_out", {31'd0, reg_file_out}, 32'd0);
        check("reset_beats_request", {16'd0, regs[5]}, 32'd0);
        check("reset_no_writes", wr_cnt, 0);
        req_valid = 1'b0;
        rst       = 1'b0;

        do_op("write_r3", OP_WRITE, 4'd3, 4'd0, 16'hBEEF, 16'hBEEF, 2, 1, 1);
        check("write_r3_reg", {16'd0, regs[3]}, 32'h0000_BEEF);
        do_op("read_r3", OP_READ, 4'd0, 4'd3, 16'h0000, 16'hBEEF, 2, 1, 0);

        do_op("write_r3b", OP_WRITE, 4'd3, 4'd0, 16'h1234, 16'h1234, 2, 1, 1);
        do_op("copy_3_15", OP_COPY, 4'd15, 4'd3, 16'h0000, 16'h1234, 3, 2, 1);
        do_op("read_r15", OP_READ, 4'd0, 4'd15, 16'h0000, 16'h1234, 2, 1, 0);
        do_op("read_r3_after", OP_READ, 4'd0, 4'd3, 16'h0000, 16'h1234, 2, 1, 0);

        do_op("write_r1", OP_WRITE, 4'd1, 4'd0, 16'hAAAA, 16'hAAAA, 2, 1, 1);
        do_op("write_r2", OP_WRITE, 4'd2, 4'd0, 16'h5555, 16'h5555, 2, 1, 1);
        do_op("swap_1_2", OP_SWAP, 4'd2, 4'd1, 16'h0000, 16'hAAAA, 5, 4, 2);
        do_op("read_r1", OP_READ, 4'd0, 4'd1, 16'h0000, 16'h5555, 2, 1, 0);
        do_op("read_r2", OP_READ, 4'd0, 4'd2, 16'h0000, 16'hAAAA, 2, 1, 0);

        do_op("write_r7", OP_WRITE, 4'd7, 4'd0, 16'h0F0F, 16'h0F0F, 2, 1, 1);
        do_op("swap_7_7", OP_SWAP, 4'd7, 4'd7, 16'h0000, 16'h0F0F, 5, 4, 2);
        do_op("read_r7", OP_READ, 4'd0, 4'd7, 16'h0000, 16'h0F0F, 2, 1, 0);

        // Reset during RD_B of a SWAP of r1 (5555) and r2 (AAAA).
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        op        = OP_SWAP;
        rd        = 4'd2;
        rs        = 4'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr0       = wr_cnt;
        @(negedge clk);
        #1;
        check("abort_rd_a_out", {31'd0, reg_file_out}, 32'd1);
        check("abort_rd_a_sel", {28'd0, register_select}, 32'd1);
        @(negedge clk);
        #1;
        check("abort_rd_b_out", {31'd0, reg_file_out}, 32'd1);
        check("abort_rd_b_sel", {28'd0, register_select}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        check("abort_select", {28'd0, register_select}, 32'd0);
        check("abort_in", {31'd0, reg_file_in}, 32'd0);
        check("abort_out", {31'd0, reg_file_out}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_r1", {16'd0, regs[1]}, 32'h0000_5555);
        check("abort_r2", {16'd0, regs[2]}, 32'h0000_AAAA);
        do_op("read_r1_after_abort", OP_READ, 4'd0, 4'd1, 16'h0000, 16'h5555, 2, 1, 0);
        do_op("read_r2_after_abort", OP_READ, 4'd0, 4'd2, 16'h0000, 16'hAAAA, 2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
